// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: mode-0 SPI initiator that runs one register write or read
// per accepted start. Frame is {rw, zero pad, addr} followed by REG_W data
// bits (wdata on a write, zeros on a read), MSB first. All outputs are
// registered; the FSM computes next values and a single register stage holds
// them, so nothing combinational reaches the pins.
module spi_host_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int FRAME_W = 8 + REG_W;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [FRAME_W-1:0] tx_sh, tx_sh_nx;
    logic [REG_W-1:0]   rx_sh, rx_sh_nx;
    logic               rw_q, rw_q_nx;
    logic               cs_n_nx, sclk_nx, mosi_nx, busy_nx, done_nx;
    logic [REG_W-1:0]   rdata_nx;
    logic [7:0]         cmd;
    logic [FRAME_W-1:0] frame;

    // Assemble the outgoing frame from the live request inputs.
    always_comb begin
        cmd    = 8'(addr);
        cmd[7] = rw;
        frame  = {cmd, (rw ? wdata : {REG_W{1'b0}})};
    end

    // Next-state and next-output logic; every phase lasts CLK_DIV cycles,
    // and a zero is shifted behind the frame so MOSI returns low after the
    // last falling edge.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        tx_sh_nx   = tx_sh;
        rx_sh_nx   = rx_sh;
        rw_q_nx    = rw_q;
        cs_n_nx    = spi_cs_n;
        sclk_nx    = spi_clk;
        mosi_nx    = spi_mosi;
        busy_nx    = busy;
        done_nx    = 1'b0;
        rdata_nx   = rdata;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                    cnt_nx   = '0;
                    rw_q_nx  = rw;
                    tx_sh_nx = frame << 1;
                    mosi_nx  = frame[FRAME_W-1];
                    cs_n_nx  = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CNT_LAST) begin
                    state_nx   = SHIFT;
                    cnt_nx     = '0;
                    bit_cnt_nx = '0;
                    sclk_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (spi_clk) begin
                        sclk_nx    = 1'b0;
                        rx_sh_nx   = (rx_sh << 1) | REG_W'(spi_miso);
                        mosi_nx    = tx_sh[FRAME_W-1];
                        tx_sh_nx   = tx_sh << 1;
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nx = HOLD;
                    end else begin
                        sclk_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    cs_n_nx  = 1'b1;
                    done_nx  = 1'b1;
                    if (!rw_q) begin
                        rdata_nx = rx_sh;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops the frame and parks the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rw_q     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            tx_sh    <= tx_sh_nx;
            rx_sh    <= rx_sh_nx;
            rw_q     <= rw_q_nx;
            spi_cs_n <= cs_n_nx;
            spi_clk  <= sclk_nx;
            spi_mosi <= mosi_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            rdata    <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Testbench for spi_host_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share
// the request inputs; a mode-0 slave model captures MOSI, drives MISO and
// times every pin against the cycle formulas of the controller.
module tb_spi_host_ctrl;

    localparam int F = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       miso;

    logic       busy0, done0, cs0, sclk0, mosi0;
    logic [7:0] rdata0;
    logic       busy1, done1, cs1, sclk1, mosi1;
    logic [7:0] rdata1;

    logic       obsCs, obsSclk, obsMosi, obsBusy, obsDone;
    logic [7:0] obsRdata;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rdModel [2];

    // Free-running system clock.
    always #5 clk = ~clk;

    spi_host_ctrl #(.CLK_DIV(2), .ADDR_W(3), .REG_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy0), .done(done0), .rdata(rdata0),
        .spi_cs_n(cs0), .spi_clk(sclk0), .spi_mosi(mosi0), .spi_miso(miso)
    );

    spi_host_ctrl #(.CLK_DIV(1), .ADDR_W(3), .REG_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1),
        .spi_cs_n(cs1), .spi_clk(sclk1), .spi_mosi(mosi1), .spi_miso(miso)
    );

    // Route the selected instance's pins to the slave model.
    always_comb begin
        obsCs    = cs0;
        obsSclk  = sclk0;
        obsMosi  = mosi0;
        obsBusy  = busy0;
        obsDone  = done0;
        obsRdata = rdata0;
        if (sel) begin
            obsCs    = cs1;
            obsSclk  = sclk1;
            obsMosi  = mosi1;
            obsBusy  = busy1;
            obsDone  = done1;
            obsRdata = rdata1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction (two when holdStart keeps start high) on instance s,
    // observed cycle by cycle with cycle 1 being the first after the edge
    // that samples start.
    task automatic applyStimulus(input bit s, input bit rwIn, input logic [2:0] addrIn,
                                 input logic [7:0] wdataIn, input logic [7:0] misoByte,
                                 input bit busyPoke, input bit holdStart);
        int dv, frames, window, secondStart;
        int rises, riseErr, viol, csFalls, csFall1, csFall2, csFallThis, csLow;
        int doneCnt, doneCyc, gap, busyLowCyc, busyAt1, bitK, misoIdx;
        logic [15:0] misoFrame, mosiCap, expFrame;
        logic [7:0] rdAtDone, expRd;
        logic prevCs, prevSc, prevMo;
        dv          = s ? 1 : 2;
        frames      = holdStart ? 2 : 1;
        window      = frames * (3 + 2 * F) * dv + 6;
        secondStart = 2 + (3 + 2 * F) * dv;
        misoFrame   = {8'($urandom), misoByte};
        expFrame    = 16'(rwIn * 32768 + addrIn * 256 + (rwIn ? wdataIn : 0));
        if (!rwIn) rdModel[s] = misoByte;
        expRd = rdModel[s];
        rises = 0; riseErr = 0; viol = 0; csFalls = 0; csFall1 = 0; csFall2 = 0;
        csFallThis = 0; csLow = 0; doneCnt = 0; doneCyc = 0; gap = 0;
        busyLowCyc = 0; busyAt1 = 0; bitK = 0; misoIdx = 0;
        mosiCap = '0; rdAtDone = '0;
        prevCs = 1'b1; prevSc = 1'b0; prevMo = 1'b0;

        @(posedge clk); #1;
        sel = s; rw = rwIn; addr = addrIn; wdata = wdataIn; start = 1'b1; miso = 1'b0;
        for (int t = 1; t <= window; t++) begin
            @(posedge clk); #1;
            if (t == 1 && !holdStart) start = 1'b0;
            if (holdStart && t == secondStart) start = 1'b0;
            if (busyPoke && t == 10) begin
                start = 1'b1; rw = ~rwIn; addr = ~addrIn; wdata = ~wdataIn;
            end
            if (busyPoke && t == 11) start = 1'b0;
            if (t == 1) busyAt1 = obsBusy;
            if (t > 1 && !obsBusy && busyLowCyc == 0) busyLowCyc = t;
            if (obsDone) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    doneCyc  = t;
                    rdAtDone = obsRdata;
                end
            end
            if (obsCs && obsBusy) gap++;
            if (obsCs && (obsSclk || obsMosi)) viol++;
            if (prevCs && !obsCs) begin
                csFalls++;
                if (csFalls == 1) csFall1 = t; else csFall2 = t;
                csFallThis = t; bitK = 0; misoIdx = 0; mosiCap = '0;
                miso = misoFrame[15];
            end
            if (!obsCs) begin
                csLow++;
                if (!prevCs && obsMosi !== prevMo && !(prevSc && !obsSclk)) viol++;
            end
            if (!prevSc && obsSclk) begin
                if (t != csFallThis + dv * (1 + 2 * bitK)) riseErr++;
                mosiCap = {mosiCap[14:0], obsMosi};
                bitK++;
                rises++;
            end
            if (prevSc && !obsSclk) begin
                misoIdx++;
                miso = (misoIdx < F) ? misoFrame[15 - misoIdx] : 1'b0;
            end
            prevCs = obsCs; prevSc = obsSclk; prevMo = obsMosi;
        end

        checkOutput("mosiFrame", 32'(mosiCap), 32'(expFrame));
        checkOutput("busyAtCycle1", 32'(busyAt1), 32'd1);
        checkOutput("csFallCycle", 32'(csFall1), 32'd1);
        if (holdStart) checkOutput("secondCsFall", 32'(csFall2), 32'(secondStart));
        else checkOutput("csFallCount", 32'(csFalls), 32'd1);
        checkOutput("csLowCycles", 32'(csLow), 32'(frames * (2 + 2 * F) * dv));
        checkOutput("doneCycle", 32'(doneCyc), 32'(1 + (2 + 2 * F) * dv));
        checkOutput("doneCount", 32'(doneCnt), 32'(frames));
        checkOutput("busyLowCycle", 32'(busyLowCyc), 32'(1 + (3 + 2 * F) * dv));
        checkOutput("gapCycles", 32'(gap), 32'(frames * dv));
        checkOutput("rdataAtDone", 32'(rdAtDone), 32'(expRd));
        checkOutput("riseCount", 32'(rises), 32'(frames * F));
        checkOutput("riseTiming", 32'(riseErr), 32'd0);
        checkOutput("mode0Violations", 32'(viol), 32'd0);
        checkOutput("rdataFinal", 32'(obsRdata), 32'(expRd));
    endtask

    // Global time bound so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence of scenarios.
    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; rw = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
        rdModel[0] = '0; rdModel[1] = '0;
        #2;
        checkOutput("rstCsN", 32'(cs0), 32'd1);
        checkOutput("rstSclk", 32'(sclk0), 32'd0);
        checkOutput("rstMosi", 32'(mosi0), 32'd0);
        checkOutput("rstBusy", 32'(busy0), 32'd0);
        checkOutput("rstDone", 32'(done0), 32'd0);
        checkOutput("rstRdata", 32'(rdata0), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        $display("[TB] write addr 2 data 0xA5");
        applyStimulus(1'b0, 1'b1, 3'd2, 8'hA5, 8'($urandom), 1'b0, 1'b0);
        $display("[TB] read addr 6 slave 0x3C");
        applyStimulus(1'b0, 1'b0, 3'd6, 8'($urandom), 8'h3C, 1'b0, 1'b0);
        $display("[TB] random transactions");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end
        $display("[TB] start while busy");
        applyStimulus(1'b0, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        $display("[TB] back-to-back");
        applyStimulus(1'b0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        @(posedge clk); #1;
        sel = 1'b0; rw = 1'b1; addr = 3'd3; wdata = 8'h5A; start = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            @(posedge clk); #1;
            if (t == 1) start = 1'b0;
        end
        checkOutput("sclkHighBit5", 32'(sclk0), 32'd1);
        checkOutput("rdataBeforeReset", 32'(rdata0), 32'(rdModel[0]));
        rst = 1'b1;
        #1;
        checkOutput("midRstCsN", 32'(cs0), 32'd1);
        checkOutput("midRstSclk", 32'(sclk0), 32'd0);
        checkOutput("midRstMosi", 32'(mosi0), 32'd0);
        checkOutput("midRstBusy", 32'(busy0), 32'd0);
        checkOutput("midRstDone", 32'(done0), 32'd0);
        checkOutput("midRstRdata", 32'(rdata0), 32'd0);
        rdModel[0] = '0; rdModel[1] = '0;
        #3 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

        $display("[TB] CLK_DIV=1 instance");
        applyStimulus(1'b1, 1'b1, 3'd7, 8'hFF, 8'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_host_ctrl.md
# spi_host_ctrl

SPI controller (initiator) that drives the four-wire SPI register interface of the chip from the host side: it generates chip-select, serial clock and MOSI, and captures MISO. It runs one register transaction per request: a write, or a read that returns the register value. It sits in the bench/FPGA harness (and any future on-chip host) opposite the chip's SPI register peripheral, and replaces bit-banged SPI in tests.

## Interface
Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period (legal range ≥1; 0 is illegal).
- ADDR_W, 3, register address width (legal range ≤7).
- REG_W, 8, register data width; FRAME_W = 8 + REG_W bits per frame.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a transaction; sampled only while busy=0
- rw  in  1  1 = write, 0 = read; latched on an accepted start
- addr  in  ADDR_W  register address; latched on an accepted start
- wdata  in  REG_W  write data; latched on an accepted start
- busy  out  1  high from the cycle after an accepted start until the end of GAP
- done  out  1  one-cycle pulse when the transaction completes
- rdata  out  REG_W  last read value; updated only by reads
- spi_cs_n  out  1  chip select, active low
- spi_clk  out  1  SCLK, idles low (mode 0)
- spi_mosi  out  1  serial data out, MSB first
- spi_miso  in  1  serial data in

## Operation
- Frame: FRAME_W bits, MSB first.
  - Command byte: {rw, (7-ADDR_W) zero bits, addr}.
  - Then REG_W data bits: wdata on a write, all zeros on a read.
- SPI mode 0:
  - MOSI is valid before each SCLK rising edge.
  - MOSI changes only on SCLK falling edges, or at CS assertion for the first bit.
- MISO sampling:
  - MISO is sampled in the last clk cycle of each SCLK high phase, on the edge that drives SCLK low.
  - This gives the slave a full half-period after the rising edge.
- State machine:
  - IDLE → SETUP: on start while in IDLE. Latch rw/addr/wdata; cs_n=0; mosi=frame[FRAME_W-1].
  - SETUP → SHIFT: after CLK_DIV cycles with sclk low.
  - SHIFT, per bit:
    - CLK_DIV cycles sclk high, then CLK_DIV cycles sclk low.
    - On the falling edge: sample MISO into a shift register and drive the next MOSI bit.
  - SHIFT → HOLD: after the FRAME_W-th falling edge. mosi=0; sclk low for CLK_DIV cycles.
  - HOLD → GAP:
    - Drive cs_n=1 and pulse done.
    - On a read, load rdata with the last REG_W sampled bits.
  - GAP → IDLE: after CLK_DIV cycles with cs_n high; busy drops on entering IDLE.
- The MISO bits captured during the command byte are discarded.
- Any start while busy=1 is ignored (not queued).
- Reset (asserted at any time, including mid-frame) forces all outputs immediately:
  - cs_n=1, sclk=0, mosi=0
  - busy=0, done=0, rdata=0
  - state=IDLE
- No partial frame is resumed after reset.

## Timing
- Cycle numbering: cycle 0 is the edge that samples start=1.
- cs_n falls at cycle 1 and stays low for (2 + 2·FRAME_W)·CLK_DIV cycles.
- First SCLK rising edge: cycle 1+CLK_DIV.
- Bit k (k=0 first): sclk rises at cycle 1+CLK_DIV·(1+2k) and falls at 1+CLK_DIV·(2+2k).
- done=1 and cs_n=1: cycle 1+(2+2·FRAME_W)·CLK_DIV. rdata is valid in the same cycle.
- busy=0: cycle 1+(3+2·FRAME_W)·CLK_DIV. A start sampled in that cycle is accepted (back-to-back).
- Defaults (CLK_DIV=2, FRAME_W=16):
  - cs_n low 68 cycles
  - done at cycle 69
  - busy low at cycle 71
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Write: CLK_DIV=2, rw=1, addr=2, wdata=0xA5 → a mode-0 slave model captures MOSI 0x82A5; done pulses at cycle 69 for exactly 1 cycle; rdata stays at 0.
- Read: rw=0, addr=6, slave model shifts 0x3C on MISO during the data byte → MOSI captured as 0x0600; rdata=0x3C at done.
- Busy ignore: a second start at cycle 10 of a transaction → no second frame; latched addr/wdata are unchanged; only one done.
- Back-to-back: start held high continuously → second cs_n falls at cycle 72; GAP high time is exactly 2 cycles; 2 done pulses.
- Reset mid-frame: rst asserted during bit 5 → same cycle cs_n=1, sclk=0, mosi=0, busy=0, rdata=0; the next transaction after release completes normally.
- CLK_DIV=1: write addr 7, wdata 0xFF → sclk period 2 cycles; MOSI 0x87FF; done at cycle 35.
